rowbuffer_ctrl: RTL and testbench

Sequencer for the 3x3 binary sliding-window row buffer. It takes the unpadded feature-map bit stream from upstream through a valid/ready handshake and inserts the border pad bits. It drives the row buffer's serial input, enable and clear, and flags each cycle where the buffer's parallel output holds a complete in-bounds window. It sits between the activation source and the majority/XNOR window datapath, and backpressures both sides.

---
 rtl/rowbuffer_ctrl.sv | 136 +++++++++++++
 tb/tb_rowbuffer_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rowbuffer_ctrl.sv
// Sequencer for the 3x3 binary sliding-window row buffer: inserts border pad bits,
// drives push/clear, and flags complete in-bounds windows. Option: ROWBUF_CTRL_PAD_ONES_EN (pad bit = 1).
module rowbuffer_ctrl #(
    parameter int unsigned K_S      = 3,
    parameter int unsigned P_N_COLS = 34,
    parameter int unsigned P_N_ROWS = 34,
    parameter int unsigned P_CNT_W  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_bit,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               rb_stream_in,
    output logic               rb_stream_in_en,
    output logic               rb_clear,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [P_CNT_W-1:0] win_row,
    output logic [P_CNT_W-1:0] win_col,
    output logic               busy,
    output logic               done
);

    localparam int unsigned PAD = (K_S - 1) / 2;
    localparam logic [P_CNT_W-1:0] PAD_LO   = P_CNT_W'(PAD);
    localparam logic [P_CNT_W-1:0] ROW_HI   = P_CNT_W'(P_N_ROWS - 1 - PAD);
    localparam logic [P_CNT_W-1:0] COL_HI   = P_CNT_W'(P_N_COLS - 1 - PAD);
    localparam logic [P_CNT_W-1:0] ROW_LAST = P_CNT_W'(P_N_ROWS - 1);
    localparam logic [P_CNT_W-1:0] COL_LAST = P_CNT_W'(P_N_COLS - 1);
    localparam logic [P_CNT_W-1:0] WIN_OFF  = P_CNT_W'(K_S - 1);

`ifdef ROWBUF_CTRL_PAD_ONES_EN
    localparam logic PAD_BIT = 1'b1;
`else
    localparam logic PAD_BIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [P_CNT_W-1:0] r, c, r_nxt, c_nxt;
    logic [P_CNT_W-1:0] win_row_nxt, win_col_nxt;
    logic               win_valid_nxt;
    logic               streaming, interior, stall, push, pos_ok;

    // State, counters and window flag registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            r         <= '0;
            c         <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            state     <= state_nxt;
            r         <= r_nxt;
            c         <= c_nxt;
            win_valid <= win_valid_nxt;
            win_row   <= win_row_nxt;
            win_col   <= win_col_nxt;
        end
    end

    // Next-state, counter advance and handshake decode
    always_comb begin
        state_nxt     = state;
        r_nxt         = r;
        c_nxt         = c;
        win_valid_nxt = win_valid && !win_ready;
        win_row_nxt   = win_row;
        win_col_nxt   = win_col;

        streaming = (state == S_STREAM);
        interior  = (r >= PAD_LO) && (r <= ROW_HI) && (c >= PAD_LO) && (c <= COL_HI);
        stall     = win_valid && !win_ready;
        push      = streaming && !stall && (!interior || in_valid);
        pos_ok    = (r >= WIN_OFF) && (c >= WIN_OFF);

        in_ready        = streaming && interior && !stall;
        rb_stream_in_en = push;
        rb_stream_in    = (streaming && interior) ? in_bit : PAD_BIT;
        rb_clear        = (state == S_CLEAR);
        busy            = (state != S_IDLE);
        done            = (state == S_DONE);

        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                r_nxt     = '0;
                c_nxt     = '0;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (push) begin
                    win_valid_nxt = pos_ok;
                    if (pos_ok) begin
                        win_row_nxt = r - WIN_OFF;
                        win_col_nxt = c - WIN_OFF;
                    end
                    // Counters freeze on the final pixel so FLUSH sees the frame end position
                    if (c == COL_LAST) begin
                        if (r == ROW_LAST) begin
                            state_nxt = S_FLUSH;
                        end else begin
                            c_nxt = '0;
                            r_nxt = r + P_CNT_W'(1);
                        end
                    end else begin
                        c_nxt = c + P_CNT_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (!win_valid || win_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rowbuffer_ctrl.sv
// Scoreboard bench for rowbuffer_ctrl: models the row buffer from the push stream
// and compares every accepted window against a golden padded-frame model.
module tb_rowbuffer_ctrl;

    localparam int NC   = 34;
    localparam int NR   = 34;
    localparam int OUTN = 32;
    localparam int SRL  = 2 * NC + 3;

`ifdef ROWBUF_CTRL_PAD_ONES_EN
    localparam logic PAD_BIT    = 1'b1;
    localparam int   EXP_CORNER = 5;
`else
    localparam logic PAD_BIT    = 1'b0;
    localparam int   EXP_CORNER = 0;
`endif

    typedef struct packed {
        logic [5:0] row;
        logic [5:0] col;
        logic [8:0] win;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, in_bit, in_valid, win_ready;
    logic       in_ready, rb_stream_in, rb_stream_in_en, rb_clear, win_valid, busy, done;
    logic [5:0] win_row, win_col;

    int   checks = 0;
    int   errors = 0;
    logic frame_data [OUTN*OUTN];
    exp_t exp_q [$];
    logic [SRL-1:0] sr = '0;
    logic [8:0] first_win;
    int   first_cyc, last_cyc, done_cyc, nwin, nhs, nclr;

    rowbuffer_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .rb_stream_in(rb_stream_in), .rb_stream_in_en(rb_stream_in_en),
        .rb_clear(rb_clear), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic pbit(input int r, input int c);
        if (r >= 1 && r <= OUTN && c >= 1 && c <= OUTN) return frame_data[(r-1)*OUTN + c - 1];
        return PAD_BIT;
    endfunction

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_push", 32'(rb_stream_in_en), 0);
        check("rst_stream_in", 32'(rb_stream_in), 32'(PAD_BIT));
        check("rst_clear", 32'(rb_clear), 0);
        check("rst_win_valid", 32'(win_valid), 0);
        check("rst_win_row", 32'(win_row), 0);
        check("rst_win_col", 32'(win_col), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
    endtask

    // Drives one frame; expectations are queued as the frame stimulus is built
    task automatic run_frame(input bit rnd, input int abort_at, input int restart_at);
        int         cyc, idx;
        bit         aborted, stall, prev_stall;
        logic [5:0] prev_row, prev_col;
        logic [8:0] w;
        exp_t       e;
        exp_q.delete();
        for (int i = 0; i < OUTN; i++) begin
            for (int j = 0; j < OUTN; j++) begin
                e.row = 6'(i);
                e.col = 6'(j);
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        e.win[dr*3+dc] = pbit(i + dr, j + dc);
                exp_q.push_back(e);
            end
        end
        idx = 0; nwin = 0; nhs = 0; nclr = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        aborted = 0; prev_stall = 0; prev_row = '0; prev_col = '0; first_win = '0;
        @(negedge clk);
        cyc = 0; start = 1'b1; in_valid = 1'b1; win_ready = 1'b1; in_bit = frame_data[0];
        while (done_cyc < 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (abort_at != 0 && cyc == abort_at) begin
                reset = 1'b0;
                aborted = 1;
                break;
            end
            win_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid  = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            in_bit    = (idx < OUTN*OUTN) ? frame_data[idx] : 1'b0;
            #1;
            stall = win_valid && !win_ready;
            if (stall) check("push_while_stalled", 32'(rb_stream_in_en), 0);
            if (prev_stall && win_valid) begin
                check("stall_row_stable", 32'(win_row), 32'(prev_row));
                check("stall_col_stable", 32'(win_col), 32'(prev_col));
            end
            if (win_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (win_valid && win_ready) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        w[dr*3+dc] = sr[(2-dr)*NC + (2-dc)];
                if (nwin == 0) first_win = w;
                nwin++;
                if (exp_q.size() == 0) begin
                    check("extra_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("win_row", 32'(win_row), 32'(e.row));
                    check("win_col", 32'(win_col), 32'(e.col));
                    check("win_bits", 32'(w), 32'(e.win));
                end
            end
            if (in_valid && in_ready) begin
                nhs++;
                idx++;
            end
            if (rb_clear) begin
                nclr++;
                sr = '0;
            end else if (rb_stream_in_en) begin
                sr = {sr[SRL-2:0], rb_stream_in};
            end
            if (done) done_cyc = cyc;
            prev_stall = stall;
            prev_row = win_row;
            prev_col = win_col;
        end
        if (aborted) begin
            @(negedge clk);
            check_reset_outputs();
            reset = 1'b1;
        end else begin
            check("frame_timeout", 32'(done_cyc < 0), 0);
            check("window_count", 32'(nwin), 1024);
            check("in_handshakes", 32'(nhs), 1024);
            check("windows_left", 32'(exp_q.size()), 0);
            check("clear_cycles", 32'(nclr), 1);
            @(negedge clk);
            check("idle_after_done", 32'(busy), 0);
            check("done_one_cycle", 32'(done), 0);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; win_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        // in_valid while IDLE must not be consumed
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 0);
            check("idle_push", 32'(rb_stream_in_en), 0);
        end

        // Checkerboard, continuous handshakes: exact cycle timing
        for (int k = 0; k < OUTN*OUTN; k++) frame_data[k] = logic'(((k / OUTN) + (k % OUTN)) & 1);
        run_frame(1'b0, 0, 0);
        check("first_win_cycle", 32'(first_cyc), 73);
        check("last_win_cycle", 32'(last_cyc), 1158);
        check("done_cycle", 32'(done_cyc), 1159);

        // Random data, random backpressure and input gaps
        for (int k = 0; k < OUTN*OUTN; k++) frame_data[k] = logic'($urandom_range(0, 1));
        run_frame(1'b1, 0, 0);

        // start pulsed mid-STREAM is ignored: timing unchanged
        run_frame(1'b0, 0, 300);
        check("restart_done_cycle", 32'(done_cyc), 1159);

        // Abort at cycle 500, then a clean frame
        run_frame(1'b0, 500, 0);
        for (int k = 0; k < OUTN*OUTN; k++) frame_data[k] = logic'(((k / OUTN) + (k % OUTN)) & 1);
        run_frame(1'b0, 0, 0);
        check("post_abort_done_cycle", 32'(done_cyc), 1159);

        // All-zero input: corner window ones come only from pad bits
        for (int k = 0; k < OUTN*OUTN; k++) frame_data[k] = 1'b0;
        run_frame(1'b1, 0, 0);
        check("corner_pad_ones", 32'($countones(first_win)), 32'(EXP_CORNER));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
